// File: rtl/arm_bus_pkg.sv
// Shared types and constants for the asynchronous register bus initiator.
//   state_t       : master FSM states
//   ADDR_W/DATA_W : bus address/data widths
//   BE_W          : byte-enable lanes
//   STROBE_OFF    : idle level of the active-low read/write strobes
//   BE_N_OFF      : idle level of the active-low byte enables
//   DEF_*         : default bus timing in clk_sys cycles
package arm_bus_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_STROBE = 2'd2,
      S_HOLD   = 2'd3
   } state_t;

   localparam int ADDR_W = 24;
   localparam int DATA_W = 32;
   localparam int BE_W   = 4;

   localparam logic            STROBE_OFF = 1'b1;
   localparam logic [BE_W-1:0] BE_N_OFF   = '1;

   localparam int DEF_SETUP_CYC     = 2;
   localparam int DEF_STROBE_CYC    = 4;
   localparam int DEF_HOLD_CYC      = 2;
   localparam int DEF_DTACK_TIMEOUT = 64;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/dtack_sync.sv
// Two-flop synchronizer for the asynchronous active-low DTACK from a responder.
//   clk    : system clock
//   rst    : asynchronous reset, active-high (flops reset to the deasserted level)
//   d_n    : raw bus_dtack_n from the pad
//   q_n    : synchronized dtack, active-low
module dtack_sync (
   input  logic clk,
   input  logic rst,
   input  logic d_n,
   output logic q_n
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d_n;
         sync_q <= meta_q;
      end
   end

   assign q_n = sync_q;

endmodule

// File: rtl/arm_bus_master.sv
// Initiator for the CPLD/EIM-style asynchronous register bus. Turns a
// single-cycle req into one timed read or write: SETUP_CYC cycles of address
// setup, STROBE_CYC cycles of strobe, HOLD_CYC cycles of hold, then a done pulse.
//   req/we/addr/wdata/be : user request, captured in IDLE
//   busy/done/rdata/err  : status; rdata valid from done, err qualified by done
//   bus_*                : registered pad-side signals (AS high, RS/WS/BE low)
//   bus_din/bus_dtack_n  : pad inputs
// Optional build macro ARM_MASTER_DTACK_EN: strobe is extended until a
// synchronized DTACK arrives, bounded by DTACK_TIMEOUT strobe cycles (err=1).
//
// state    | meaning
// S_IDLE   | bus released, waiting for req
// S_SETUP  | AS/address/BE (and write data) valid, strobes high
// S_STROBE | RS_B or WS_B low
// S_HOLD   | strobes high, address/BE/data still driven
module arm_bus_master
   import arm_bus_pkg::*;
#(
   parameter int SETUP_CYC     = DEF_SETUP_CYC,
   parameter int STROBE_CYC    = DEF_STROBE_CYC,
   parameter int HOLD_CYC      = DEF_HOLD_CYC,
   parameter int DTACK_TIMEOUT = DEF_DTACK_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [BE_W-1:0]   be,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic [ADDR_W-1:0] bus_a,
   output logic [BE_W-1:0]   bus_be_n,
   output logic              bus_as,
   output logic              bus_rs_n,
   output logic              bus_ws_n,
   output logic [DATA_W-1:0] bus_dout,
   output logic              bus_doe,
   input  logic [DATA_W-1:0] bus_din,
   input  logic              bus_dtack_n
);

   localparam int CNT_MAX = max3(SETUP_CYC, STROBE_CYC, HOLD_CYC);
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d, cnt_dec;
   logic              we_q, we_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] bus_a_q, bus_a_d;
   logic [BE_W-1:0]   bus_be_n_q, bus_be_n_d;
   logic              bus_as_q, bus_as_d;
   logic              bus_rs_n_q, bus_rs_n_d;
   logic              bus_ws_n_q, bus_ws_n_d;
   logic [DATA_W-1:0] bus_dout_q, bus_dout_d;
   logic              bus_doe_q, bus_doe_d;
   logic              strobe_exit;

`ifdef ARM_MASTER_DTACK_EN
   localparam int TW = (DTACK_TIMEOUT > 1) ? $clog2(DTACK_TIMEOUT) : 1;

   logic          dtack_s_n;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          to_q, to_d;

   dtack_sync u_dtack_sync (
      .clk (clk),
      .rst (rst),
      .d_n (bus_dtack_n),
      .q_n (dtack_s_n)
   );

   // Minimum strobe width first, then wait for DTACK or the timeout.
   assign strobe_exit = (cnt_q == '0) && (!dtack_s_n || (tmo_q == '0));

   // Timeout budget is reloaded while in SETUP so it is full on strobe entry.
   always_comb begin
      tmo_d = tmo_q;
      to_d  = to_q;
      if (state_q == S_IDLE) begin
         to_d = 1'b0;
      end else if (state_q == S_SETUP) begin
         tmo_d = TW'(DTACK_TIMEOUT - 1);
      end else if (state_q == S_STROBE) begin
         if (tmo_q != '0) tmo_d = tmo_q - TW'(1);
         if (strobe_exit && dtack_s_n) to_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_q <= '0;
         to_q  <= 1'b0;
      end else begin
         tmo_q <= tmo_d;
         to_q  <= to_d;
      end
   end
`else
   logic unused_dtack;
   assign unused_dtack = bus_dtack_n & (DTACK_TIMEOUT != 0);
   assign strobe_exit  = (cnt_q == '0);
`endif

   assign cnt_dec = (cnt_q != '0) ? cnt_q - CW'(1) : '0;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      rdata_d    = rdata_q;
      err_d      = err_q;
      bus_a_d    = bus_a_q;
      bus_be_n_d = bus_be_n_q;
      bus_as_d   = bus_as_q;
      bus_rs_n_d = bus_rs_n_q;
      bus_ws_n_d = bus_ws_n_q;
      bus_dout_d = bus_dout_q;
      bus_doe_d  = bus_doe_q;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               state_d    = S_SETUP;
               cnt_d      = CW'(SETUP_CYC - 1);
               we_d       = we;
               busy_d     = 1'b1;
               err_d      = 1'b0;
               bus_a_d    = addr;
               bus_be_n_d = ~be;
               bus_as_d   = 1'b1;
               if (we) begin
                  bus_dout_d = wdata;
                  bus_doe_d  = 1'b1;
               end
            end
         end
         S_SETUP: begin
            cnt_d = cnt_dec;
            if (cnt_q == '0) begin
               state_d    = S_STROBE;
               cnt_d      = CW'(STROBE_CYC - 1);
               bus_rs_n_d = we_q ? STROBE_OFF : ~STROBE_OFF;
               bus_ws_n_d = we_q ? ~STROBE_OFF : STROBE_OFF;
            end
         end
         S_STROBE: begin
            cnt_d = cnt_dec;
            if (strobe_exit) begin
               state_d    = S_HOLD;
               cnt_d      = CW'(HOLD_CYC - 1);
               bus_rs_n_d = STROBE_OFF;
               bus_ws_n_d = STROBE_OFF;
               if (!we_q) rdata_d = bus_din;
            end
         end
         S_HOLD: begin
            cnt_d = cnt_dec;
            if (cnt_q == '0) begin
               state_d    = S_IDLE;
               busy_d     = 1'b0;
               done_d     = 1'b1;
               bus_as_d   = 1'b0;
               bus_doe_d  = 1'b0;
               bus_be_n_d = BE_N_OFF;
`ifdef ARM_MASTER_DTACK_EN
               err_d      = to_q;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         we_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         bus_a_q    <= '0;
         bus_be_n_q <= BE_N_OFF;
         bus_as_q   <= 1'b0;
         bus_rs_n_q <= STROBE_OFF;
         bus_ws_n_q <= STROBE_OFF;
         bus_dout_q <= '0;
         bus_doe_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         we_q       <= we_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         bus_a_q    <= bus_a_d;
         bus_be_n_q <= bus_be_n_d;
         bus_as_q   <= bus_as_d;
         bus_rs_n_q <= bus_rs_n_d;
         bus_ws_n_q <= bus_ws_n_d;
         bus_dout_q <= bus_dout_d;
         bus_doe_q  <= bus_doe_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign rdata    = rdata_q;
   assign err      = err_q;
   assign bus_a    = bus_a_q;
   assign bus_be_n = bus_be_n_q;
   assign bus_as   = bus_as_q;
   assign bus_rs_n = bus_rs_n_q;
   assign bus_ws_n = bus_ws_n_q;
   assign bus_dout = bus_dout_q;
   assign bus_doe  = bus_doe_q;

endmodule

// File: tb/tb_arm_bus_master.sv
// Directed bench for arm_bus_master with default timing (2/4/2).
// Cycle c=1 is the cycle after the edge that accepts req; outputs sampled on negedge.
module tb_arm_bus_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [23:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  be = '0;
   logic        busy, done, err;
   logic [31:0] rdata;
   logic [23:0] bus_a;
   logic [3:0]  bus_be_n;
   logic        bus_as, bus_rs_n, bus_ws_n, bus_doe;
   logic [31:0] bus_dout;
   logic [31:0] bus_din = '0;
   logic        bus_dtack_n = 1'b0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   arm_bus_master dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
      .busy(busy), .done(done), .rdata(rdata), .err(err),
      .bus_a(bus_a), .bus_be_n(bus_be_n), .bus_as(bus_as), .bus_rs_n(bus_rs_n),
      .bus_ws_n(bus_ws_n), .bus_dout(bus_dout), .bus_doe(bus_doe),
      .bus_din(bus_din), .bus_dtack_n(bus_dtack_n)
   );

   // Stimulus only: present a request and return right after the accepting edge.
   task automatic start(input logic w, input logic [23:0] a, input logic [31:0] d, input logic [3:0] b);
      @(negedge clk);
      req = 1'b1; we = w; addr = a; wdata = d; be = b;
      @(posedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (bus_as !== 1'b0 || bus_rs_n !== 1'b1 || bus_ws_n !== 1'b1 || bus_doe !== 1'b0) begin
         errors++; $display("FAIL reset_strobes as=%b rs_n=%b ws_n=%b doe=%b exp 0/1/1/0", bus_as, bus_rs_n, bus_ws_n, bus_doe); end
      checks++; if (bus_be_n !== 4'hF || bus_a !== 24'h0 || bus_dout !== 32'h0) begin
         errors++; $display("FAIL reset_bus be_n=%h a=%h dout=%h exp F/0/0", bus_be_n, bus_a, bus_dout); end
      checks++; if (busy !== 1'b0 || done !== 1'b0 || rdata !== 32'h0 || err !== 1'b0) begin
         errors++; $display("FAIL reset_status busy=%b done=%b rdata=%h err=%b exp 0/0/0/0", busy, done, rdata, err); end
      rst = 1'b0;
   endtask

   task automatic test_write;
      logic e_as, e_ws;
      start(1'b1, 24'h000010, 32'hDEADBEEF, 4'hF);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk); req = 1'b0;
         e_as = (c <= 8);
         e_ws = !(c >= 3 && c <= 6);
         checks++; if (bus_as !== e_as) begin errors++; $display("FAIL write_as c=%0d got %b exp %b", c, bus_as, e_as); end
         checks++; if (bus_ws_n !== e_ws) begin errors++; $display("FAIL write_ws_n c=%0d got %b exp %b", c, bus_ws_n, e_ws); end
         checks++; if (bus_rs_n !== 1'b1) begin errors++; $display("FAIL write_rs_n c=%0d got %b exp 1", c, bus_rs_n); end
         checks++; if (bus_doe !== e_as) begin errors++; $display("FAIL write_doe c=%0d got %b exp %b", c, bus_doe, e_as); end
         checks++; if (done !== (c == 9)) begin errors++; $display("FAIL write_done c=%0d got %b exp %b", c, done, (c == 9)); end
         checks++; if (busy !== e_as) begin errors++; $display("FAIL write_busy c=%0d got %b exp %b", c, busy, e_as); end
         if (c <= 8) begin
            checks++; if (bus_a !== 24'h000010 || bus_dout !== 32'hDEADBEEF || bus_be_n !== 4'h0) begin
               errors++; $display("FAIL write_bus c=%0d a=%h dout=%h be_n=%h exp 000010/DEADBEEF/0", c, bus_a, bus_dout, bus_be_n); end
         end else begin
            checks++; if (bus_be_n !== 4'hF) begin errors++; $display("FAIL write_be_idle c=%0d got %h exp F", c, bus_be_n); end
         end
         if (c == 9) begin
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL write_err got %b exp 0", err); end
         end
      end
   endtask

   task automatic test_read;
      logic e_as, e_rs;
      bus_din = 32'h0;
      start(1'b0, 24'h000004, 32'h11111111, 4'hF);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk); req = 1'b0;
         bus_din = (c >= 3 && c <= 6) ? 32'hCAFEF00D : 32'h0;
         e_as = (c <= 8);
         e_rs = !(c >= 3 && c <= 6);
         checks++; if (bus_rs_n !== e_rs) begin errors++; $display("FAIL read_rs_n c=%0d got %b exp %b", c, bus_rs_n, e_rs); end
         checks++; if (bus_ws_n !== 1'b1) begin errors++; $display("FAIL read_ws_n c=%0d got %b exp 1", c, bus_ws_n); end
         checks++; if (bus_doe !== 1'b0) begin errors++; $display("FAIL read_doe c=%0d got %b exp 0", c, bus_doe); end
         checks++; if (bus_as !== e_as) begin errors++; $display("FAIL read_as c=%0d got %b exp %b", c, bus_as, e_as); end
         checks++; if (done !== (c == 9)) begin errors++; $display("FAIL read_done c=%0d got %b exp %b", c, done, (c == 9)); end
         if (c == 9) begin
            checks++; if (rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL read_rdata got %h exp CAFEF00D", rdata); end
         end
      end
   endtask

   task automatic test_back_to_back;
      logic e_rs;
      start(1'b1, 24'h000020, 32'h0BADF00D, 4'b0101);
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk); req = 1'b0;
         if (c <= 8) begin
            checks++; if (bus_be_n !== 4'b1010) begin errors++; $display("FAIL b2b_be_n c=%0d got %b exp 1010", c, bus_be_n); end
         end
      end
      checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_first_done done=%b busy=%b exp 1/0", done, busy); end
      checks++; if (rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_rdata_kept got %h exp CAFEF00D", rdata); end
      // New request presented in the done cycle.
      req = 1'b1; we = 1'b0; addr = 24'h000008; be = 4'hF; bus_din = 32'h12345678;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk); req = 1'b0;
         e_rs = !(c >= 3 && c <= 6);
         if (c == 1) begin
            checks++; if (bus_as !== 1'b1 || busy !== 1'b1 || bus_a !== 24'h000008) begin
               errors++; $display("FAIL b2b_second_start as=%b busy=%b a=%h exp 1/1/000008", bus_as, busy, bus_a); end
         end
         checks++; if (bus_rs_n !== e_rs) begin errors++; $display("FAIL b2b_rs_n c=%0d got %b exp %b", c, bus_rs_n, e_rs); end
         checks++; if (done !== (c == 9)) begin errors++; $display("FAIL b2b_done c=%0d got %b exp %b", c, done, (c == 9)); end
      end
      checks++; if (rdata !== 32'h12345678) begin errors++; $display("FAIL b2b_rdata got %h exp 12345678", rdata); end
      bus_din = 32'h0;
   endtask

   task automatic test_ignored_req;
      int n_done;
      n_done = 0;
      start(1'b1, 24'h000030, 32'h55AA55AA, 4'hF);
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 10) req = 1'b0;
         if (done) n_done++;
         checks++; if (done !== (c == 9 || c == 18)) begin
            errors++; $display("FAIL ignore_done c=%0d got %b exp %b", c, done, (c == 9 || c == 18)); end
         if (c == 9 || c == 10) begin
            checks++; if (bus_as !== (c == 10)) begin errors++; $display("FAIL ignore_as c=%0d got %b exp %b", c, bus_as, (c == 10)); end
         end
      end
      checks++; if (n_done != 2) begin errors++; $display("FAIL ignore_done_count got %0d exp 2", n_done); end
   endtask

   task automatic test_reset_mid;
      start(1'b1, 24'h000040, 32'hA5A5A5A5, 4'hF);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk); req = 1'b0;
      end
      checks++; if (bus_ws_n !== 1'b0) begin errors++; $display("FAIL rstmid_pre_ws_n got %b exp 0", bus_ws_n); end
      #2 rst = 1'b1;
      #1;
      checks++; if (bus_ws_n !== 1'b1 || bus_doe !== 1'b0 || bus_as !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL rstmid_async ws_n=%b doe=%b as=%b busy=%b exp 1/0/0/0", bus_ws_n, bus_doe, bus_as, busy); end
      @(negedge clk); rst = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         checks++; if (done !== 1'b0 || busy !== 1'b0 || bus_as !== 1'b0) begin
            errors++; $display("FAIL rstmid_idle c=%0d done=%b busy=%b as=%b exp 0/0/0", c, done, busy, bus_as); end
      end
   endtask

`ifdef ARM_MASTER_DTACK_EN
   task automatic test_dtack_extend;
      int n_low;
      n_low = 0;
      @(negedge clk); bus_dtack_n = 1'b1;
      start(1'b1, 24'h000050, 32'h01020304, 4'hF);
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk); req = 1'b0;
         if (!bus_ws_n) n_low++;
         if (c == 12) bus_dtack_n = 1'b0;
         if (c == 17) begin
            checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL dtack_ext_done done=%b err=%b exp 1/0", done, err); end
         end
      end
      checks++; if (n_low != 12) begin errors++; $display("FAIL dtack_ext_len got %0d exp 12", n_low); end
   endtask

   task automatic test_dtack_timeout;
      int n_low;
      n_low = 0;
      @(negedge clk); bus_dtack_n = 1'b1;
      start(1'b1, 24'h000060, 32'h0A0B0C0D, 4'hF);
      for (int c = 1; c <= 70; c++) begin
         @(negedge clk); req = 1'b0;
         if (!bus_ws_n) n_low++;
         if (c == 69) begin
            checks++; if (done !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL dtack_tmo_done done=%b err=%b exp 1/1", done, err); end
         end
      end
      checks++; if (n_low != 64) begin errors++; $display("FAIL dtack_tmo_len got %0d exp 64", n_low); end
      bus_dtack_n = 1'b0;
      start(1'b1, 24'h000064, 32'h0, 4'hF);
      @(negedge clk); req = 1'b0;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL dtack_err_clear got %b exp 0", err); end
      repeat (10) @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_ignored_req();
      test_reset_mid();
`ifdef ARM_MASTER_DTACK_EN
      test_dtack_extend();
      test_dtack_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
